// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the pipelined parallel-prefix adder.
// Latency is derived here so the RTL and its users agree on it.
package adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int ngrp_of(input int w, input int re);
        return (clog2(w) + re - 1) / re;
    endfunction

    function automatic int lat_of(input int w, input int re);
        return ngrp_of(w, re) + 2;
    endfunction

endpackage

// File: rtl/gp_prefix_cell.sv
// Kogge-Stone black cell: merges a higher (G,P) span with the adjacent lower span.
module gp_prefix_cell
    import adder_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = hi.p & lo.p;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a global-stall valid/ready pipe
// and a sideband tag that travels with each operation.
module pipelined_prefix_adder
    import adder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG2W = clog2(WIDTH);
    localparam int NGRP  = ngrp_of(WIDTH, REG_EVERY);
    localparam int LAT   = lat_of(WIDTH, REG_EVERY);

    logic             adv;
    logic [LAT-1:0]   vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] tag_d [LAT];
    gp_t [WIDTH-1:0]  gp_q [NGRP+1];
    gp_t [WIDTH-1:0]  gp_d [NGRP+1];
    logic [WIDTH-1:0] p_q [NGRP+1];
    logic [WIDTH-1:0] p_d [NGRP+1];
    logic [NGRP:0]    c0_q, c0_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] bx;
    logic             c0;
    gp_t [WIDTH-1:0]  s1_gp;
    logic [WIDTH:0]   carry;
    logic             unused_p;

    assign adv      = !vld_q[LAT-1] | out_ready;
    assign in_ready = adv;

    always_comb begin
        bx = in_sub ? ~in_b : in_b;
        c0 = in_sub | in_cin;
        for (int i = 0; i < WIDTH; i++) begin
            s1_gp[i].g = in_a[i] & bx[i];
            s1_gp[i].p = in_a[i] ^ bx[i];
        end
        // Carry-in folded into bit 0 so the prefix tree needs no extra input.
        s1_gp[0].g = s1_gp[0].g | (s1_gp[0].p & c0);
    end

    assign gp_d[0] = s1_gp;

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        for (genvar j = 0; j < REG_EVERY; j++) begin : g_lvl
            localparam int K = gi * REG_EVERY + j;
            localparam int S = (K < LOG2W) ? (1 << K) : WIDTH;
            gp_t [WIDTH-1:0] src;
            gp_t [WIDTH-1:0] dst;
            if (j == 0) begin : g_in
                assign src = gp_q[gi];
            end else begin : g_chain
                assign src = g_lvl[j-1].dst;
            end
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i >= S) begin : g_cell
                    gp_prefix_cell u_cell (
                        .hi (src[i]),
                        .lo (src[i-S]),
                        .o  (dst[i])
                    );
                end else begin : g_wire
                    assign dst[i] = src[i];
                end
            end
        end
        assign gp_d[gi+1] = g_lvl[REG_EVERY-1].dst;
    end

    always_comb begin
        vld_d    = {vld_q[LAT-2:0], in_valid};
        tag_d[0] = in_tag;
        for (int s = 1; s < LAT; s++) tag_d[s] = tag_q[s-1];
        p_d[0]  = in_a ^ bx;
        c0_d[0] = c0;
        for (int s = 1; s <= NGRP; s++) begin
            p_d[s]  = p_q[s-1];
            c0_d[s] = c0_q[s-1];
        end
    end

    always_comb begin
        carry[0] = c0_q[NGRP];
        unused_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = gp_q[NGRP][i].g;
            unused_p   = unused_p ^ gp_q[NGRP][i].p;
        end
        sum_d  = p_q[NGRP] ^ carry[WIDTH-1:0];
        cout_d = carry[WIDTH];
        ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
            for (int s = 0; s <= NGRP; s++) begin
                gp_q[s] <= '0;
                p_q[s]  <= '0;
            end
            c0_q   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_d;
            tag_q  <= tag_d;
            gp_q   <= gp_d;
            p_q    <= p_d;
            c0_q   <= c0_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed and scoreboarded bench for pipelined_prefix_adder, plus a width sweep.
module tb_pipelined_prefix_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic        in_cin, in_sub;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready;
    logic [15:0] out_sum;
    logic        out_cout, out_ovf;
    logic [3:0]  out_tag;

    int checks;
    int failures;

    logic        sw_valid;
    logic [63:0] sw_a, sw_b;
    logic        sw_cin, sw_sub;
    logic [3:0]  sw_tag;
    logic [4:0]  sw_rdy, sw_v, sw_cout, sw_ovf;
    logic [3:0]  sw_otag [5];
    logic [63:0] sw_sum [5];
    logic [0:0]  o_w1r1;
    logic [4:0]  o_w5r1, o_w5r3;
    logic [63:0] o_w64r1, o_w64r3;
    int          sw_w   [5] = '{1, 5, 5, 64, 64};
    int          sw_lat [5] = '{2, 5, 3, 8, 4};

    assign sw_sum[0] = 64'(o_w1r1);
    assign sw_sum[1] = 64'(o_w5r1);
    assign sw_sum[2] = 64'(o_w5r3);
    assign sw_sum[3] = o_w64r1;
    assign sw_sum[4] = o_w64r3;

    pipelined_prefix_adder #(.WIDTH(16), .REG_EVERY(2), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_tag(out_tag)
    );

    pipelined_prefix_adder #(.WIDTH(1), .REG_EVERY(1), .TAG_W(4)) u_w1r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[0]),
        .in_a(sw_a[0:0]), .in_b(sw_b[0:0]), .in_cin(sw_cin), .in_sub(sw_sub),
        .in_tag(sw_tag), .out_valid(sw_v[0]), .out_ready(1'b1),
        .out_sum(o_w1r1), .out_cout(sw_cout[0]), .out_ovf(sw_ovf[0]),
        .out_tag(sw_otag[0])
    );

    pipelined_prefix_adder #(.WIDTH(5), .REG_EVERY(1), .TAG_W(4)) u_w5r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[1]),
        .in_a(sw_a[4:0]), .in_b(sw_b[4:0]), .in_cin(sw_cin), .in_sub(sw_sub),
        .in_tag(sw_tag), .out_valid(sw_v[1]), .out_ready(1'b1),
        .out_sum(o_w5r1), .out_cout(sw_cout[1]), .out_ovf(sw_ovf[1]),
        .out_tag(sw_otag[1])
    );

    pipelined_prefix_adder #(.WIDTH(5), .REG_EVERY(3), .TAG_W(4)) u_w5r3 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[2]),
        .in_a(sw_a[4:0]), .in_b(sw_b[4:0]), .in_cin(sw_cin), .in_sub(sw_sub),
        .in_tag(sw_tag), .out_valid(sw_v[2]), .out_ready(1'b1),
        .out_sum(o_w5r3), .out_cout(sw_cout[2]), .out_ovf(sw_ovf[2]),
        .out_tag(sw_otag[2])
    );

    pipelined_prefix_adder #(.WIDTH(64), .REG_EVERY(1), .TAG_W(4)) u_w64r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[3]),
        .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
        .in_tag(sw_tag), .out_valid(sw_v[3]), .out_ready(1'b1),
        .out_sum(o_w64r1), .out_cout(sw_cout[3]), .out_ovf(sw_ovf[3]),
        .out_tag(sw_otag[3])
    );

    pipelined_prefix_adder #(.WIDTH(64), .REG_EVERY(3), .TAG_W(4)) u_w64r3 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[4]),
        .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
        .in_tag(sw_tag), .out_valid(sw_v[4]), .out_ready(1'b1),
        .out_sum(o_w64r3), .out_cout(sw_cout[4]), .out_ovf(sw_ovf[4]),
        .out_tag(sw_otag[4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} with sum masked to w bits.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic cin,
                                            input logic sub);
        logic [64:0] mask, aa, bb, full;
        logic [63:0] s;
        logic        c0, co, ov;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & mask;
        bb   = {1'b0, (sub ? ~b : b)} & mask;
        c0   = sub | cin;
        full = aa + bb + {64'd0, c0};
        s    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s};
    endfunction

    task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub, input logic [3:0] tag,
                           output int lat, output logic [21:0] got);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = {out_ovf, out_cout, out_sum, out_tag};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_sum !== 16'h0) begin
                failures++;
                $display("FAIL reset_hold: valid=%b sum=%h required valid=0 sum=0000",
                         out_valid, out_sum);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_add();
        int          lat;
        logic [21:0] got;
        run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd5, lat, got);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL add_latency: got %0d required 4", lat);
        end
        checks++;
        if (got !== {1'b0, 1'b1, 16'h0000, 4'd5}) begin
            failures++;
            $display("FAIL add_wrap: got %h required %h", got, {1'b0, 1'b1, 16'h0000, 4'd5});
        end
        run_one(16'h7FFF, 16'h0000, 1'b1, 1'b0, 4'd1, lat, got);
        checks++;
        if (got !== {1'b1, 1'b0, 16'h8000, 4'd1}) begin
            failures++;
            $display("FAIL add_cin_ovf: got %h required %h", got, {1'b1, 1'b0, 16'h8000, 4'd1});
        end
        run_one(16'h1234, 16'h4321, 1'b0, 1'b0, 4'd2, lat, got);
        checks++;
        if (got !== {1'b0, 1'b0, 16'h5555, 4'd2}) begin
            failures++;
            $display("FAIL add_plain: got %h required %h", got, {1'b0, 1'b0, 16'h5555, 4'd2});
        end
        run_one(16'h8000, 16'h8000, 1'b0, 1'b0, 4'd4, lat, got);
        checks++;
        if (got !== {1'b1, 1'b1, 16'h0000, 4'd4}) begin
            failures++;
            $display("FAIL add_neg_ovf: got %h required %h", got, {1'b1, 1'b1, 16'h0000, 4'd4});
        end
    endtask

    task automatic test_sub();
        int          lat;
        logic [21:0] got;
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 4'd3, lat, got);
        checks++;
        if (got !== {1'b1, 1'b1, 16'h7FFF, 4'd3}) begin
            failures++;
            $display("FAIL sub_ovf: got %h required %h", got, {1'b1, 1'b1, 16'h7FFF, 4'd3});
        end
        run_one(16'h0000, 16'h0001, 1'b0, 1'b1, 4'd9, lat, got);
        checks++;
        if (got !== {1'b0, 1'b0, 16'hFFFF, 4'd9}) begin
            failures++;
            $display("FAIL sub_borrow: got %h required %h", got, {1'b0, 1'b0, 16'hFFFF, 4'd9});
        end
        run_one(16'h0005, 16'h0005, 1'b0, 1'b1, 4'd6, lat, got);
        checks++;
        if (got !== {1'b0, 1'b1, 16'h0000, 4'd6}) begin
            failures++;
            $display("FAIL sub_cin_ignored: got %h required %h", got, {1'b0, 1'b1, 16'h0000, 4'd6});
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] exp_q [$];
        logic [21:0] exp;
        logic [65:0] r;
        logic [22:0] prev_out;
        logic        stall_prev;
        int          sent, rcvd, cyc;
        sent = 0; rcvd = 0; cyc = 0; stall_prev = 1'b0; prev_out = '0;
        while ((sent < 200 || rcvd < 200) && cyc < 4000) begin
            @(negedge clk);
            if (sent < 200) begin
                in_valid = 1'b1;
                in_a     = 16'($urandom);
                in_b     = 16'($urandom);
                in_cin   = 1'($urandom);
                in_sub   = 1'($urandom);
                in_tag   = sent[3:0];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 9) >= 3);
            #1;
            if (stall_prev) begin
                checks++;
                if ({out_valid, out_ovf, out_cout, out_sum, out_tag} !== prev_out) begin
                    failures++;
                    $display("FAIL stall_stable: got %h required %h",
                             {out_valid, out_ovf, out_cout, out_sum, out_tag}, prev_out);
                end
            end
            if (in_valid && in_ready) begin
                r = ref_add(16, 64'(in_a), 64'(in_b), in_cin, in_sub);
                exp_q.push_back({r[65:64], r[15:0], in_tag});
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra: got %h required nothing",
                             {out_ovf, out_cout, out_sum, out_tag});
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_ovf, out_cout, out_sum, out_tag} !== exp) begin
                        failures++;
                        $display("FAIL stream_result %0d: got %h required %h", rcvd,
                                 {out_ovf, out_cout, out_sum, out_tag}, exp);
                    end
                end
                rcvd++;
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_valid, out_ovf, out_cout, out_sum, out_tag};
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd !== 200 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL stream_count: got %0d pending %0d required 200 pending 0",
                     rcvd, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int          ghosts, lat;
        logic [21:0] got;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 16'h1111 * 16'(i + 1); in_b = 16'h0001;
            in_cin = 1'b0; in_sub = 1'b0; in_tag = 4'(10 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flight_valid: out_valid=%b required 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_tag !== 4'h0) begin
            failures++;
            $display("FAIL async_reset: valid=%b sum=%h tag=%h required 0 0000 0",
                     out_valid, out_sum, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        ghosts = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        checks++;
        if (ghosts !== 0) begin
            failures++;
            $display("FAIL flush: got %0d results required 0", ghosts);
        end
        run_one(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 4'd7, lat, got);
        checks++;
        if (lat !== 4 || got !== {1'b0, 1'b0, 16'h1000, 4'd7}) begin
            failures++;
            $display("FAIL post_reset_op: lat=%0d got %h required lat=4 %h",
                     lat, got, {1'b0, 1'b0, 16'h1000, 4'd7});
        end
    endtask

    task automatic test_sweep();
        logic [63:0] va [8];
        logic [63:0] vb [8];
        logic        vc [8];
        logic        vs [8];
        logic [4:0]  seen;
        logic [65:0] r;
        va[0] = '1; vb[0] = 64'd0; vc[0] = 1'b1; vs[0] = 1'b0;
        va[1] = '1; vb[1] = '1;    vc[1] = 1'b1; vs[1] = 1'b0;
        va[2] = '1; vb[2] = 64'd1; vc[2] = 1'b0; vs[2] = 1'b0;
        va[3] = 64'd0; vb[3] = 64'd1; vc[3] = 1'b0; vs[3] = 1'b1;
        for (int v = 4; v < 8; v++) begin
            va[v] = {$urandom, $urandom};
            vb[v] = {$urandom, $urandom};
            vc[v] = 1'($urandom);
            vs[v] = 1'($urandom);
        end
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            sw_valid = 1'b1; sw_a = va[v]; sw_b = vb[v];
            sw_cin = vc[v]; sw_sub = vs[v]; sw_tag = 4'(v);
            #1;
            checks++;
            if (sw_rdy !== 5'b11111) begin
                failures++;
                $display("FAIL sweep_ready: got %b required 11111", sw_rdy);
            end
            seen = '0;
            for (int lat = 1; lat <= 12; lat++) begin
                @(negedge clk);
                sw_valid = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    if (!seen[k] && sw_v[k]) begin
                        seen[k] = 1'b1;
                        r = ref_add(sw_w[k], va[v], vb[v], vc[v], vs[v]);
                        checks++;
                        if (lat !== sw_lat[k]) begin
                            failures++;
                            $display("FAIL sweep_latency w%0d#%0d: got %0d required %0d",
                                     sw_w[k], k, lat, sw_lat[k]);
                        end
                        checks++;
                        if ({sw_ovf[k], sw_cout[k], sw_sum[k], sw_otag[k]} !== {r, 4'(v)}) begin
                            failures++;
                            $display("FAIL sweep_result w%0d#%0d v%0d: got %h required %h",
                                     sw_w[k], k, v,
                                     {sw_ovf[k], sw_cout[k], sw_sum[k], sw_otag[k]}, {r, 4'(v)});
                        end
                    end
                end
            end
            checks++;
            if (seen !== 5'b11111) begin
                failures++;
                $display("FAIL sweep_timeout v%0d: seen %b required 11111", v, seen);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        in_tag = '0; out_ready = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_tag = '0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
